// File: rtl/timer_pkg.sv
// Shared types and defaults for the ms timing blocks (interval meter,
// delay timer): FSM state encoding and default counter width.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        HOLD    = 2'd2
    } meter_state_t;

    localparam int DEFAULT_MS_WIDTH    = 10;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/tick_sync.sv
// Synchronises an asynchronous 1 kHz tick source into the clk domain and
// emits a one-clk pulse per rising edge.
// Ports: clk, rst_n (async active-low), async_in (raw tick source),
//        tick (1-clk pulse, SYNC_STAGES+1 clk after an async_in rise).
module tick_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;
    logic                   tick_q;
    logic                   tick_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
        tick_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // Chain and history reset high so a source that is already high when
    // reset releases is not mistaken for a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/interval_meter.sv
// Measures the time between a start and a stop pulse in whole 1 ms ticks
// and presents the count on a valid/ready hold.
// Ports: clk, rst_n (async active-low), clk1kHz (async 1 ms source),
//        start/stop (1-clk pulses), result_ready (consumer accept),
//        result_valid/result/overflow (held result), busy (measuring),
//        elapsed (live count while measuring, frozen otherwise).
module interval_meter
    import timer_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_MS_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk1kHz,
    input  logic             start,
    input  logic             stop,
    input  logic             result_ready,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             busy,
    output logic [WIDTH-1:0] elapsed
);

    localparam logic [WIDTH-1:0] MAX_CNT = '1;
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    meter_state_t     state_q;
    meter_state_t     state_d;
    logic [WIDTH-1:0] counter_q;
    logic [WIDTH-1:0] counter_d;
    logic             overflow_q;
    logic             overflow_d;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;

    logic             tick;
    logic [WIDTH-1:0] cnt_inc;
    logic             inc_sat;

    tick_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_tick_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(clk1kHz),
        .tick    (tick)
    );

    // Saturating increment: the tick that lands on MAX_CNT, or any tick
    // after it, flags overflow; the counter never wraps.
    always_comb begin
        inc_sat = (counter_q == MAX_CNT) || (counter_q == MAX_CNT - ONE);
        if (counter_q == MAX_CNT) begin
            cnt_inc = MAX_CNT;
        end else begin
            cnt_inc = counter_q + ONE;
        end
    end

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        overflow_d = overflow_q;
        result_d   = result_q;
        unique case (state_q)
            IDLE: begin
                if (start && stop) begin
                    state_d    = HOLD;
                    result_d   = '0;
                    overflow_d = 1'b0;
                end else if (start) begin
                    state_d    = RUNNING;
                    counter_d  = '0;
                    overflow_d = 1'b0;
                end
            end
            RUNNING: begin
                if (tick) begin
                    counter_d  = cnt_inc;
                    overflow_d = overflow_q | inc_sat;
                end
                // stop has priority; a tick in the same clk is included.
                if (stop) begin
                    state_d  = HOLD;
                    result_d = counter_d;
                end else if (start) begin
                    counter_d  = '0;
                    overflow_d = 1'b0;
                end
            end
            HOLD: begin
                if (result_ready) begin
                    if (start) begin
                        state_d    = RUNNING;
                        counter_d  = '0;
                        overflow_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_q <= '0;
        end else begin
            counter_q <= counter_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            result_q   <= '0;
        end else begin
            overflow_q <= overflow_d;
            result_q   <= result_d;
        end
    end

    assign result_valid = (state_q == HOLD);
    assign busy         = (state_q == RUNNING);
    assign result       = result_q;
    assign overflow     = overflow_q;
    assign elapsed      = counter_q;

endmodule

// File: tb/tb_interval_meter.sv
// Scoreboard bench for interval_meter: a 10-bit and a 4-bit instance
// share stimulus; expected results are queued and popped on handshake.
module tb_interval_meter;

    typedef struct {
        int   res;
        logic ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk1kHz = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic ready = 1'b0;

    logic       rv_a, ovf_a, busy_a;
    logic [9:0] res_a, el_a;
    logic       rv_b, ovf_b, busy_b;
    logic [3:0] res_b, el_b;

    int n_checks = 0;
    int n_fail = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    interval_meter #(.WIDTH(10), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .clk1kHz(clk1kHz),
        .start(start), .stop(stop), .result_ready(ready),
        .result_valid(rv_a), .result(res_a), .overflow(ovf_a),
        .busy(busy_a), .elapsed(el_a)
    );

    interval_meter #(.WIDTH(4), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .clk1kHz(clk1kHz),
        .start(start), .stop(stop), .result_ready(ready),
        .result_valid(rv_b), .result(res_b), .overflow(ovf_b),
        .busy(busy_b), .elapsed(el_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int ra, input logic oa,
                        input int rb, input logic ob);
        exp_t e;
        e.res = ra; e.ovf = oa; q_a.push_back(e);
        e.res = rb; e.ovf = ob; q_b.push_back(e);
    endtask

    // Monitors: pop and compare on every accepted result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rv_a && ready) begin
            if (q_a.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL a_unexpected: got %0d expected none", res_a);
            end else begin
                e = q_a.pop_front();
                chk("a_result", int'(res_a), e.res);
                chk("a_overflow", int'(ovf_a), int'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rv_b && ready) begin
            if (q_b.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL b_unexpected: got %0d expected none", res_b);
            end else begin
                e = q_b.pop_front();
                chk("b_result", int'(res_b), e.res);
                chk("b_overflow", int'(ovf_b), int'(e.ovf));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ms_tick(input int n);
        for (int i = 0; i < n; i++) begin
            #3 clk1kHz = 1'b1;
            cyc(4);
            #3 clk1kHz = 1'b0;
            cyc(4);
        end
    endtask

    task automatic pulse(input logic s, input logic p);
        @(posedge clk); #1;
        start = s; stop = p;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic handshake();
        @(posedge clk); #1;
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(3);
        chk("rst_valid", int'(rv_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_result", int'(res_a), 0);
        chk("rst_elapsed", int'(el_a), 0);
        chk("rst_overflow", int'(ovf_a), 0);
        rst_n = 1'b1;
        cyc(3);
        chk("idle_no_tick", int'(el_a), 0);

        // 1: five ticks
        pulse(1'b1, 1'b0);
        chk("t1_busy", int'(busy_a), 1);
        ms_tick(5);
        chk("t1_elapsed", int'(el_a), 5);
        push(5, 1'b0, 5, 1'b0);
        pulse(1'b0, 1'b1);
        chk("t1_valid", int'(rv_a), 1);
        chk("t1_busy_off", int'(busy_a), 0);
        cyc(5);
        chk("t1_valid_held", int'(rv_a), 1);
        handshake();
        chk("t1_valid_drop", int'(rv_a), 0);

        // 2: saturation (4-bit instance)
        pulse(1'b1, 1'b0);
        ms_tick(20);
        chk("t2_el_b", int'(el_b), 15);
        chk("t2_el_a", int'(el_a), 20);
        chk("t2_live_ovf_b", int'(ovf_b), 1);
        push(20, 1'b0, 15, 1'b1);
        pulse(1'b0, 1'b1);
        handshake();

        // 3: restart mid-measurement
        pulse(1'b1, 1'b0);
        ms_tick(3);
        pulse(1'b1, 1'b0);
        chk("t3_restart", int'(el_a), 0);
        ms_tick(2);
        push(2, 1'b0, 2, 1'b0);
        pulse(1'b0, 1'b1);
        handshake();

        // 4a: start&stop in IDLE
        push(0, 1'b0, 0, 1'b0);
        pulse(1'b1, 1'b1);
        chk("t4_valid", int'(rv_a), 1);
        chk("t4_result", int'(res_a), 0);
        handshake();

        // 4b: start&stop in RUNNING, stop wins
        pulse(1'b1, 1'b0);
        ms_tick(2);
        push(2, 1'b0, 2, 1'b0);
        pulse(1'b1, 1'b1);
        chk("t4b_valid", int'(rv_a), 1);
        chk("t4b_busy", int'(busy_a), 0);
        handshake();

        // 5: HOLD ignores ticks, stop and start without ready
        pulse(1'b1, 1'b0);
        ms_tick(4);
        push(4, 1'b0, 4, 1'b0);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        ms_tick(1);
        pulse(1'b1, 1'b0);
        cyc(10);
        chk("t5_held_result", int'(res_a), 4);
        chk("t5_held_valid", int'(rv_a), 1);
        chk("t5_held_busy", int'(busy_a), 0);
        @(posedge clk); #1;
        ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0; start = 1'b0;
        chk("t5_valid_off", int'(rv_a), 0);
        chk("t5_busy_on", int'(busy_a), 1);
        chk("t5_counter0", int'(el_a), 0);
        ms_tick(1);
        push(1, 1'b0, 1, 1'b0);
        pulse(1'b0, 1'b1);
        handshake();

        // 6: reset mid-run with clk1kHz high
        pulse(1'b1, 1'b0);
        ms_tick(2);
        #3 clk1kHz = 1'b1;
        cyc(5);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", int'(busy_a), 0);
        chk("t6_elapsed", int'(el_a), 0);
        chk("t6_valid", int'(rv_a), 0);
        chk("t6_busy_b", int'(busy_b), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        pulse(1'b1, 1'b0);
        cyc(10);
        chk("t6_no_tick", int'(el_a), 0);
        clk1kHz = 1'b0;
        cyc(4);
        ms_tick(1);
        chk("t6_next_tick", int'(el_a), 1);
        push(1, 1'b0, 1, 1'b0);
        pulse(1'b0, 1'b1);
        handshake();

        cyc(3);
        chk("q_a_drained", q_a.size(), 0);
        chk("q_b_drained", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
